dm_lsu: RTL
===========

DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data word width; ADDR_W, default 12, data-memory word-address width.
REQ-002 The module SHALL use clock clk and reset reset, where reset is asynchronous and active-high.
REQ-003 Clock and reset ports SHALL be: clk  in  1  clock; reset  in  1  async active-high reset.
REQ-004 Request ports SHALL be: req_valid  in  1  request present; req_ready  out  1  request accepted when both high; req_we  in  1  1=store, 0=load; req_size  in  2  00 byte, 01 half, 10 word, 11 illegal; req_signed  in  1  sign-extend sub-word load; req_addr  in  ADDR_W+2  byte address; req_wdata  in  DATA_W  store data, right-aligned.
REQ-005 Response ports SHALL be: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  DATA_W  load result (0 for stores and errors); rsp_err  out  1  misaligned or illegal size.
REQ-006 Data-memory ports SHALL be: enable_mem  out  1; enable_fetch  out  1; enable_writeback  out  1; dm_in_address  out  ADDR_W  write word address; dm_out_address  out  ADDR_W  read word address; dm_wdata  out  DATA_W  write data; dm_rdata  in  DATA_W  memory read data, valid the cycle after a fetch edge.

Function
REQ-007 FSM states SHALL be IDLE, RD, CAP, MERGE, WR, ERR.
REQ-008 req_ready SHALL be 1 only in IDLE; a handshake in cycle N SHALL register all request fields.
REQ-009 Word address SHALL be addr[ADDR_W+1:2]; byte lane k SHALL be bits 8k+7:8k (little-endian); halfword h SHALL be bits 16h+15:16h with h=addr[1].
REQ-010 Misaligned requests (half with addr[0]=1, word with addr[1:0]!=0) or req_size=11 SHALL go IDLE->ERR, assert no memory enable, and produce rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle N+2.
REQ-011 A load SHALL go IDLE->RD->CAP->IDLE; RD (N+1) SHALL drive enable_mem=1, enable_fetch=1 and dm_out_address=word address.
REQ-012 In CAP (N+2), the selected lane of dm_rdata SHALL be extracted, zero- or sign-extended per req_signed, and registered so that rsp_valid=1 with rsp_rdata is seen in N+3.
REQ-013 A word store SHALL go IDLE->WR->IDLE; WR (N+1) SHALL drive enable_mem=1, enable_writeback=1, dm_in_address=word address and dm_wdata=req_wdata; rsp_valid SHALL be asserted in N+2.
REQ-014 A byte or half store SHALL read-modify-write: IDLE->RD (N+1)->MERGE (N+2), which replaces only the addressed lane with the low bits of req_wdata, ->WR (N+3)->IDLE; rsp_valid SHALL be asserted in N+4.
REQ-015 enable_fetch SHALL be 1 only in RD, enable_writeback only in WR, and enable_mem only in RD or WR; all other states SHALL drive all enables to 0.
REQ-016 dm_in_address and dm_out_address SHALL always equal the registered word address; dm_wdata SHALL be 0 outside WR.
REQ-017 rsp_valid SHALL be a registered single-cycle pulse with no backpressure; rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-018 A new request SHALL be acceptable in the same cycle as the previous rsp_valid (back-to-back, no bubble).
REQ-019 req_signed SHALL be ignored for stores and word loads.

Reset
REQ-020 While reset is asserted, state SHALL be IDLE and every output SHALL be 0, except req_ready, which SHALL be 1 after reset is released.
REQ-021 Reset in any state SHALL abort the operation: no writeback pulse and no rsp_valid for the aborted request.

Structure
REQ-022 Package dm_lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, DATA_W and ADDR_W.
REQ-023 A combinational sub-module dm_lsu_align SHALL perform lane extract/extend and store merge; the FSM and registers SHALL reside in dm_lsu.

Verification
REQ-024 Word store 0xDEADBEEF to addr 0x010 SHALL produce one enable_writeback cycle with dm_in_address=0x004 and rsp_valid at N+2; a subsequent word load SHALL return 0xDEADBEEF at N+3.
REQ-025 After the REQ-024 store, a signed byte load at 0x011 SHALL return 0xFFFFFFBE, and an unsigned byte load at 0x011 SHALL return 0x000000BE.
REQ-026 A half store of 0x1234 at 0x012 SHALL perform an RD then WR with dm_wdata=0x1234BEEF and rsp_valid at N+4.
REQ-027 A word load at 0x013 SHALL give rsp_err=1 and rsp_rdata=0 at N+2, with all enables held at 0 throughout.
REQ-028 Reset asserted during MERGE of a byte store SHALL leave enable_writeback at 0, rsp_valid at 0 and state IDLE.
REQ-029 With req_valid held high for two loads, the second SHALL be accepted in the rsp_valid cycle of the first.

Source files
------------

// File: rtl/dm_lsu_pkg.sv
// dm_lsu_pkg: shared widths, size encodings, FSM states and request legality check.
package dm_lsu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, CAP, MERGE, WR, ERR} state_t;
  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] off);
    return size == 2'b11 || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/dm_lsu_align.sv
// dm_lsu_align: little-endian lane extract with zero/sign extension, and sub-word store merge.
module dm_lsu_align
  import dm_lsu_pkg::*;
#(
  parameter int DATA_W = dm_lsu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              sgn,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[8*lane +: 8];
  assign h = rdata[16*lane[1] +: 16];
  always_comb begin
    load_data = size == SZ_BYTE ? {{(DATA_W-8){sgn & b[7]}}, b}
              : size == SZ_HALF ? {{(DATA_W-16){sgn & h[15]}}, h} : rdata;
    merged = rdata;
    if (size == SZ_BYTE) merged[8*lane +: 8] = wdata[7:0];
    else if (size == SZ_HALF) merged[16*lane[1] +: 16] = wdata[15:0];
  end
endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: single-port data-memory load/store unit; sub-word stores are read-modify-write.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int DATA_W = dm_lsu_pkg::DATA_W,
  parameter int ADDR_W = dm_lsu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              enable_mem,
  output logic              enable_fetch,
  output logic              enable_writeback,
  output logic [ADDR_W-1:0] dm_in_address,
  output logic [ADDR_W-1:0] dm_out_address,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);
  state_t            state, next;
  logic              we_q, sgn_q;
  logic [1:0]        size_q, lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wbuf, load_data, merged;

  dm_lsu_align #(.DATA_W(DATA_W)) u_align (
    .rdata(dm_rdata), .wdata(wbuf), .size(size_q), .lane(lane_q), .sgn(sgn_q),
    .load_data(load_data), .merged(merged)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE:  if (req_valid) next = bad_req(req_size, req_addr[1:0]) ? ERR
                                 : (req_we && req_size == SZ_WORD) ? WR : RD;
      RD:    next = we_q ? MERGE : CAP;
      MERGE: next = WR;
      default: next = IDLE;
    endcase
    req_ready        = state == IDLE && !reset;
    enable_fetch     = state == RD;
    enable_writeback = state == WR;
    enable_mem       = enable_fetch || enable_writeback;
    dm_in_address    = addr_q;
    dm_out_address   = addr_q;
    dm_wdata         = state == WR ? wbuf : '0;
  end

  // wbuf holds store data; for sub-word stores MERGE overwrites it with the merged word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      lane_q    <= 2'b00;
      addr_q    <= '0;
      wbuf      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= next;
      rsp_valid <= state == CAP || state == WR || state == ERR;
      rsp_err   <= state == ERR;
      rsp_rdata <= state == CAP ? load_data : '0;
      if (req_valid && state == IDLE) begin
        we_q   <= req_we;
        sgn_q  <= req_signed;
        size_q <= req_size;
        lane_q <= req_addr[1:0];
        addr_q <= req_addr[ADDR_W+1:2];
        wbuf   <= req_wdata;
      end
      if (state == MERGE) wbuf <= merged;
    end
  end
endmodule
